hold_arbiter: RTL and testbench
===============================

Name: hold_arbiter

Overview:
- Shares one movement/action resource between N_REQ held request lines, e.g. stretched key or event pulses from the input holders.
- Grants exactly one requester at a time, for a fixed minimum window, then enforces a dead gap before re-arbitrating.
- Sits between the input conditioning stage and the player/game-logic FSM, so only one held command drives the datapath per window.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- GRANT_TIME, 4, cycles each grant is held; must be ≥1.
- GAP_TIME, 1, cycles of all-zero grant after each window; must be ≥1.
- CNT_WIDTH, 26, width of the internal window counter; must hold max(GRANT_TIME, GAP_TIME)-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  level requests; bit i high = requester i wants the resource.
- grant  output  N_REQ  registered, one-hot or all-zero; bit i = requester i owns the resource.
- grant_start  output  1  registered one-cycle pulse in the first cycle of every grant window.
- busy  output  1  registered; high while in GRANT or GAP.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately, also mid-window):
  - grant=0, grant_start=0, busy=0, counter=0, state=IDLE.
  - last_winner=N_REQ-1, so the first round-robin search starts at index 0.
- States: IDLE, GRANT, GAP (2-bit encoding).
- IDLE:
  - grant=0, busy=0.
  - If req≠0, a winner is selected combinationally from the current req.
  - On the next edge: grant=onehot(winner), grant_start=1, busy=1, counter=0, last_winner=winner, state=GRANT.
  - Latency from a sampled req to asserted grant is one edge.
  - If req=0, stay in IDLE.
- GRANT:
  - grant held constant; grant_start=0 after the first cycle.
  - counter increments each cycle.
  - When counter==GRANT_TIME-1: next edge grant=0, counter=0, state=GAP.
  - Grant spans exactly GRANT_TIME cycles.
  - Non-preemptive: req changes, including the winner dropping its req, neither shorten nor extend the window.
- GAP:
  - grant=0, busy=1.
  - When counter==GAP_TIME-1: next edge state=IDLE, busy=0, counter=0.
  - Gap spans exactly GAP_TIME cycles.
- Requests are level-sensitive and never latched:
  - A req that rises and falls entirely within GRANT/GAP is lost.
  - A req still high in IDLE is served.
- Default selection is fixed priority: lowest set index wins.
- Minimum period between grant_start pulses is GRANT_TIME+GAP_TIME+1 cycles; the +1 is the IDLE arbitration cycle.
- Invariants:
  - grant never has more than one bit set.
  - grant_start never high while grant=0.
  - busy = (state≠IDLE).

Optional Feature:
- Macro: HOLD_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - Search for the winner starts at (last_winner+1) mod N_REQ and wraps upward; the first set bit wins.
  - Any continuously asserted requester is granted within N_REQ windows.
- Undefined:
  - Fixed lowest-index priority.
  - last_winner is still maintained but does not affect selection.

Test Plan:
- Async reset: during GRANT with grant=4'b0100, pull rst_n low between edges → grant=0, busy=0, grant_start=0 before the next edge. Release rst_n with req=0 → stays IDLE.
- Single short request (GRANT_TIME=4, GAP_TIME=2): req=4'b0100 for one cycle in IDLE → next edge grant=4'b0100 for 4 cycles, grant_start high on the first of them only, then grant=0 for 2 cycles. busy high for 6 cycles, then low.
- Non-preemption: winner req[1] drops after 1 cycle of GRANT while req[0] rises → grant=4'b0010 for the full 4 cycles. req[0] is granted only after GAP and one IDLE cycle.
- Fixed priority (macro undefined): req=4'b1010 held constant → every window grants 4'b0010; 4'b1000 is never granted.
- Round robin (macro defined): req=4'b1111 held → grant sequence 0001, 0010, 0100, 1000, 0001. Consecutive grant_start pulses are GRANT_TIME+GAP_TIME+1 cycles apart.
- Boundary (GRANT_TIME=1, GAP_TIME=1): req=4'b0001 held → grant is a 1-cycle pulse coincident with grant_start, repeating every 3 cycles.

Source files
------------

// File: rtl/hold_arbiter.sv
// ============================================================================
// Module   : hold_arbiter
// Brief    : Grants one of N_REQ held requests for a fixed window, then a dead
//            gap. Define HOLD_ARBITER_ROUND_ROBIN_EN for round-robin selection.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hold_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GRANT_TIME = 4,
  parameter int GAP_TIME   = 1,
  parameter int CNT_WIDTH  = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_start,
  output logic             busy
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] C_GRANT_LAST = CNT_WIDTH'(GRANT_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] C_GAP_LAST   = CNT_WIDTH'(GAP_TIME - 1);
  localparam logic [N_REQ-1:0]     C_ONE        = N_REQ'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 grant_start_q, grant_start_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     last_winner_q, last_winner_d;

  logic [IDX_W-1:0]     winner;

  // Winner search over the live request vector; the first set bit in search order wins.
  always_comb begin
    int idx;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef HOLD_ARBITER_ROUND_ROBIN_EN
      idx = (int'(last_winner_q) + 1 + k) % N_REQ;
`else
      idx = k;
`endif
      if (req[idx]) begin
        winner = IDX_W'(idx);
      end
    end
  end

`ifndef HOLD_ARBITER_ROUND_ROBIN_EN
  logic unused_last_winner;
  assign unused_last_winner = ^last_winner_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      grant_q       <= '0;
      grant_start_q <= 1'b0;
      busy_q        <= 1'b0;
      last_winner_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      grant_start_q <= grant_start_d;
      busy_q        <= busy_d;
      last_winner_q <= last_winner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (cnt_q == C_GRANT_LAST) begin
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == C_GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_d       = '0;
    grant_start_d = 1'b0;
    last_winner_d = last_winner_q;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d       = C_ONE << winner;
          grant_start_d = 1'b1;
          last_winner_d = winner;
        end
      end
      S_GRANT: begin
        if (cnt_q != C_GRANT_LAST) begin
          grant_d = grant_q;
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_start = grant_start_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_hold_arbiter.sv
// ============================================================================
// Module   : tb_hold_arbiter
// Brief    : Random-stimulus bench for hold_arbiter, two parameter sets, each
//            compared with a window-age reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hold_arbiter;

  localparam int N     = 4;
  localparam int GT_A  = 4;
  localparam int GAP_A = 2;
  localparam int GT_B  = 1;
  localparam int GAP_B = 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req   = '0;

  logic [N-1:0] grant_a, grant_b;
  logic         gs_a, gs_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, whether a window is active, its age since grant_start, owner, last winner.
  int m_active [2];
  int m_age    [2];
  int m_owner  [2];
  int m_last   [2];
  int m_gt     [2];
  int m_gap    [2];

  always #5 clk = ~clk;

  hold_arbiter #(.N_REQ(N), .GRANT_TIME(GT_A), .GAP_TIME(GAP_A), .CNT_WIDTH(26)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_a), .grant_start(gs_a), .busy(busy_a)
  );

  hold_arbiter #(.N_REQ(N), .GRANT_TIME(GT_B), .GAP_TIME(GAP_B), .CNT_WIDTH(26)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_b), .grant_start(gs_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef HOLD_ARBITER_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0;
      m_age[i]    = 0;
      m_owner[i]  = 0;
      m_last[i]   = N - 1;
    end
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    for (int i = 0; i < 2; i++) begin
      if (m_active[i] == 0) begin
        w = pick(r, m_last[i]);
        if (w >= 0) begin
          m_active[i] = 1;
          m_age[i]    = 0;
          m_owner[i]  = w;
          m_last[i]   = w;
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == m_gt[i] + m_gap[i]) m_active[i] = 0;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [N-1:0] g, input logic s, input logic b);
    logic [N-1:0] eg;
    eg = '0;
    if (m_active[i] != 0 && m_age[i] < m_gt[i]) eg[m_owner[i]] = 1'b1;
    check(i == 0 ? "grant_a" : "grant_b", 32'(g), 32'(eg));
    check(i == 0 ? "gstart_a" : "gstart_b", 32'(s), 32'(m_active[i] != 0 && m_age[i] == 0));
    check(i == 0 ? "busy_a" : "busy_b", 32'(b), 32'(m_active[i] != 0));
    check(i == 0 ? "onehot_a" : "onehot_b", 32'($onehot0(g)), 32'd1);
  endtask

  task automatic step(input logic [N-1:0] next_req);
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    check_dut(0, grant_a, gs_a, busy_a);
    check_dut(1, grant_b, gs_b, busy_b);
    req = next_req;
  endtask

  task automatic run_random(input int n);
    logic [N-1:0] held;
    logic [N-1:0] nr;
    held = '0;
    for (int c = 0; c < n; c++) begin
      if (c % 30 == 0) held = N'($urandom);
      case ((c / 30) % 4)
        0:       nr = N'($urandom);
        1:       nr = held;
        2:       nr = ($urandom % 6 == 0) ? (N'(1) << ($urandom % N)) : '0;
        default: nr = '1;
      endcase
      step(nr);
    end
  endtask

  initial begin
    bit found;
    m_gt[0] = GT_A;  m_gap[0] = GAP_A;
    m_gt[1] = GT_B;  m_gap[1] = GAP_B;
    model_reset();

    #1 rst_n = 1'b0;
    #11;
    check("rst_grant_a", 32'(grant_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_gstart_b", 32'(gs_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = '0;

    step(4'b0000);
    step(4'b0100);
    step(4'b0000);
    run_random(600);

    // Asynchronous reset in the middle of a grant window of instance A.
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (m_active[0] != 0 && m_age[0] == 1) found = 1;
      else step(4'b0100);
    end
    check("rst_window_found", 32'(found), 32'd1);
    @(posedge clk);
    model_step(req);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_grant_a", 32'(grant_a), 32'd0);
    check("arst_gstart_a", 32'(gs_a), 32'd0);
    check("arst_busy_a", 32'(busy_a), 32'd0);
    check("arst_grant_b", 32'(grant_b), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) step(4'b0000);
    run_random(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
